// File: rtl/hilo_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned DIV_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_e;

    // Operand bundle presented to the multiply/divide unit.
    typedef struct packed {
        logic              sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } md_op_t;

    function automatic int unsigned cnt_width(input int unsigned mul_lat,
                                              input int unsigned div_lat);
        int unsigned m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(MUL_LAT_DEF, DIV_LAT_DEF);

endpackage

// File: rtl/hilo_sequencer_if.sv
// Pipeline/unit-facing signal bundle of hilo_sequencer.
interface hilo_sequencer_if;
    import hilo_pkg::*;

    logic              start_i;
    logic              op_div_i;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic              wr_hi_i;
    logic              wr_lo_i;
    logic [DATA_W-1:0] wdata_i;
    logic              rd_hi_i;
    logic              rd_lo_i;
    logic              flush_i;
    logic [DATA_W-1:0] rdata_o;
    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] md_a_o;
    logic [DATA_W-1:0] md_b_o;
    logic              md_en_o;
    logic              md_sel_o;
    logic [DATA_W-1:0] md_high_i;
    logic [DATA_W-1:0] md_low_i;

    modport slave (
        input  start_i, op_div_i, op_a_i, op_b_i, wr_hi_i, wr_lo_i, wdata_i,
               rd_hi_i, rd_lo_i, flush_i, md_high_i, md_low_i,
        output rdata_o, stall_o, busy_o, done_o, md_a_o, md_b_o, md_en_o, md_sel_o
    );

    modport master (
        output start_i, op_div_i, op_a_i, op_b_i, wr_hi_i, wr_lo_i, wdata_i,
               rd_hi_i, rd_lo_i, flush_i, md_high_i, md_low_i,
        input  rdata_o, stall_o, busy_o, done_o, md_a_o, md_b_o, md_en_o, md_sel_o
    );

endinterface

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter timing the multiply/divide latency; zero_o flags the capture cycle.
module hilo_lat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// Sequences MULT/DIV through the external unit and owns the HI/LO registers.
// Optional HILO_FWD_EN: MFHI/MFLO are served from the unit outputs during the capture cycle.
module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input logic             clk,
    input logic             rst,
    hilo_sequencer_if.slave bus
);

    localparam int unsigned CW_REQ = cnt_width(MUL_LAT, DIV_LAT);
    localparam int unsigned CW     = (CW_REQ > CNT_W) ? CW_REQ : CNT_W;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    md_op_t            op_q, op_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic [CW-1:0]     cnt_val;
    logic              cnt_zero;
    logic              busy_c;
    logic              capture_c;
    logic              rd_any_c;
    logic              rd_stall_c;

    hilo_lat_counter #(.W(CW)) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Next-state: accept in IDLE (start beats MTHI/MTLO), count down, capture or squash.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = MUL_LOAD;
        case (state_q)
            IDLE: begin
                if (!bus.flush_i) begin
                    if (bus.start_i) begin
                        op_d     = '{sel: bus.op_div_i, a: bus.op_a_i, b: bus.op_b_i};
                        cnt_load = 1'b1;
                        cnt_val  = bus.op_div_i ? DIV_LOAD : MUL_LOAD;
                        state_d  = bus.op_div_i ? DIV_BUSY : MUL_BUSY;
                    end else begin
                        if (bus.wr_hi_i) hi_d = bus.wdata_i;
                        if (bus.wr_lo_i) lo_d = bus.wdata_i;
                    end
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    hi_d    = bus.md_high_i;
                    lo_d    = bus.md_low_i;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign busy_c    = (state_q != IDLE);
    assign capture_c = busy_c && cnt_zero;
    assign rd_any_c  = bus.rd_hi_i || bus.rd_lo_i;

`ifdef HILO_FWD_EN
    assign rd_stall_c  = rd_any_c && !capture_c;
    assign bus.rdata_o = capture_c ? (bus.rd_hi_i ? bus.md_high_i : bus.md_low_i)
                                   : (bus.rd_hi_i ? hi_q : lo_q);
`else
    assign rd_stall_c  = rd_any_c;
    assign bus.rdata_o = bus.rd_hi_i ? hi_q : lo_q;
`endif

    assign bus.stall_o  = busy_c && (bus.start_i || bus.wr_hi_i || bus.wr_lo_i || rd_stall_c);
    assign bus.busy_o   = busy_c;
    assign bus.done_o   = done_q;
    assign bus.md_a_o   = op_q.a;
    assign bus.md_b_o   = op_q.b;
    assign bus.md_sel_o = op_q.sel;
    assign bus.md_en_o  = busy_c;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: directed literal cases, then randomized traffic vs a transaction model.
module tb_hilo_sequencer;
    import hilo_pkg::*;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 1;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    hilo_sequencer_if bus ();

    hilo_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behaviour of the external mul_div_unit: {outH, outL}.
    function automatic logic [63:0] unit_fn(input logic sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel) return 64'(a) * 64'(b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic int unsigned lat_of(input logic sel);
        return sel ? DIV_LAT : MUL_LAT;
    endfunction

    // Unit model: result is only valid once en has been held for the op's latency.
    int unsigned en_cyc = 0;
    logic [63:0] unit_r;
    always @(posedge clk) en_cyc <= bus.md_en_o ? en_cyc + 1 : 0;
    always_comb begin
        unit_r = unit_fn(bus.md_sel_o, bus.md_a_o, bus.md_b_o);
        if (bus.md_en_o && (en_cyc + 1 == lat_of(bus.md_sel_o))) begin
            bus.md_high_i = unit_r[63:32];
            bus.md_low_i  = unit_r[31:0];
        end else begin
            bus.md_high_i = 32'h5A5A_5A5A;
            bus.md_low_i  = 32'hA5A5_A5A5;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: pending op with edges-left and precomputed result.
    logic [31:0] m_hi, m_lo, m_a, m_b, m_res_hi, m_res_lo;
    logic        m_sel, m_active, m_done;
    int unsigned m_left;
    logic [63:0] m_r;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sel = 0;
            m_res_hi = 0; m_res_lo = 0; m_active = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (bus.flush_i) m_active = 1'b0;
                else if (m_left == 1) begin
                    m_hi = m_res_hi; m_lo = m_res_lo; m_active = 1'b0; m_done = 1'b1;
                end else m_left--;
            end else if (!bus.flush_i) begin
                if (bus.start_i) begin
                    m_a = bus.op_a_i; m_b = bus.op_b_i; m_sel = bus.op_div_i;
                    m_r = unit_fn(m_sel, m_a, m_b);
                    m_res_hi = m_r[63:32]; m_res_lo = m_r[31:0];
                    m_left = lat_of(m_sel); m_active = 1'b1;
                end else begin
                    if (bus.wr_hi_i) m_hi = bus.wdata_i;
                    if (bus.wr_lo_i) m_lo = bus.wdata_i;
                end
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        logic        cap, e_stall;
        logic [31:0] e_rdata;
        if (chk_en) begin
            cap     = m_active && (m_left == 1);
            e_stall = m_active && (bus.start_i || bus.wr_hi_i || bus.wr_lo_i ||
                      ((bus.rd_hi_i || bus.rd_lo_i) && !(FWD && cap)));
            e_rdata = (FWD && cap) ? (bus.rd_hi_i ? m_res_hi : m_res_lo)
                                   : (bus.rd_hi_i ? m_hi : m_lo);
            check("m_stall", 32'(bus.stall_o), 32'(e_stall));
            check("m_rdata", bus.rdata_o, e_rdata);
            check("m_busy", 32'(bus.busy_o), 32'(m_active));
            check("m_en", 32'(bus.md_en_o), 32'(m_active));
            check("m_done", 32'(bus.done_o), 32'(m_done));
            check("m_md_a", bus.md_a_o, m_a);
            check("m_md_b", bus.md_b_o, m_b);
            check("m_md_sel", 32'(bus.md_sel_o), 32'(m_sel));
        end
    end

    task automatic clear_inputs();
        bus.start_i = 0; bus.op_div_i = 0; bus.op_a_i = 0; bus.op_b_i = 0;
        bus.wr_hi_i = 0; bus.wr_lo_i = 0; bus.wdata_i = 0;
        bus.rd_hi_i = 0; bus.rd_lo_i = 0; bus.flush_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic div, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1; bus.op_div_i = div; bus.op_a_i = a; bus.op_b_i = b;
        tick();
        bus.start_i = 0;
    endtask

    initial begin
        bit held;
        int unsigned r;
        rst = 1'b1;
        clear_inputs();
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        bus.rd_hi_i = 1;
        @(negedge clk);
        check("rst_rdata_hi", bus.rdata_o, 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_md_en", 32'(bus.md_en_o), 32'd0);
        tick(); bus.rd_hi_i = 0;

        // MULT 7*6: en high two cycles, then done with LO=42, HI=0.
        launch(1'b0, 32'd7, 32'd6);
        @(negedge clk); check("mul_en0", 32'(bus.md_en_o), 32'd1);
        tick();
        @(negedge clk); check("mul_en1", 32'(bus.md_en_o), 32'd1);
        tick(); bus.rd_lo_i = 1;
        @(negedge clk);
        check("mul_en_off", 32'(bus.md_en_o), 32'd0);
        check("mul_done", 32'(bus.done_o), 32'd1);
        check("mul_lo", bus.rdata_o, 32'd42);
        tick(); bus.rd_lo_i = 0; bus.rd_hi_i = 1;
        @(negedge clk);
        check("mul_hi", bus.rdata_o, 32'd0);
        check("mul_done_pulse", 32'(bus.done_o), 32'd0);
        tick(); bus.rd_hi_i = 0;

        // DIV 100/7: HI=quotient 14, LO=remainder 2.
        launch(1'b1, 32'd100, 32'd7);
        @(negedge clk); check("div_busy", 32'(bus.busy_o), 32'd1);
        tick(); bus.rd_hi_i = 1;
        @(negedge clk);
        check("div_hi", bus.rdata_o, 32'd14);
        check("div_done", 32'(bus.done_o), 32'd1);
        tick(); bus.rd_hi_i = 0; bus.rd_lo_i = 1;
        @(negedge clk); check("div_lo", bus.rdata_o, 32'd2);
        tick(); bus.rd_lo_i = 0;

        // MFLO one cycle after start of MULT 7*6.
        launch(1'b0, 32'd7, 32'd6);
        bus.rd_lo_i = 1;
        @(negedge clk); check("mflo_stall0", 32'(bus.stall_o), 32'd1);
        tick();
        @(negedge clk);
        check("mflo_stall_cap", 32'(bus.stall_o), FWD ? 32'd0 : 32'd1);
        if (FWD) check("mflo_fwd", bus.rdata_o, 32'd42);
        tick();
        @(negedge clk);
        check("mflo_stall_after", 32'(bus.stall_o), 32'd0);
        check("mflo_after", bus.rdata_o, 32'd42);
        tick(); bus.rd_lo_i = 0;

        // Flush during MULT 3*3 with LO=5.
        bus.wr_lo_i = 1; bus.wdata_i = 32'd5;
        tick(); bus.wr_lo_i = 0;
        launch(1'b0, 32'd3, 32'd3);
        bus.flush_i = 1;
        @(negedge clk); check("flush_busy", 32'(bus.busy_o), 32'd1);
        tick(); bus.flush_i = 0; bus.rd_lo_i = 1;
        @(negedge clk);
        check("flush_idle", 32'(bus.busy_o), 32'd0);
        check("flush_lo", bus.rdata_o, 32'd5);
        tick();
        @(negedge clk);
        check("flush_nodone", 32'(bus.done_o), 32'd0);
        check("flush_lo_kept", bus.rdata_o, 32'd5);
        tick(); bus.rd_lo_i = 0;

        // MTHI then MFHI.
        bus.wr_hi_i = 1; bus.wdata_i = 32'hDEAD_BEEF;
        tick(); bus.wr_hi_i = 0; bus.rd_hi_i = 1;
        @(negedge clk); check("mthi_mfhi", bus.rdata_o, 32'hDEAD_BEEF);
        tick(); bus.rd_hi_i = 0;

        // start + MTLO together: mult wins, LO write dropped.
        bus.wr_lo_i = 1; bus.wdata_i = 32'h1234;
        launch(1'b0, 32'd2, 32'd3);
        bus.wr_lo_i = 0;
        @(negedge clk); check("coll_busy", 32'(bus.busy_o), 32'd1);
        tick(); tick(); bus.rd_lo_i = 1;
        @(negedge clk); check("coll_lo", bus.rdata_o, 32'd6);
        tick(); clear_inputs();

        // Randomized traffic; stalled requests are held.
        held = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!held) begin
                r = $urandom_range(0, 9);
                bus.start_i  = (r <= 2) || (r == 8);
                bus.op_div_i = 1'($urandom_range(0, 1));
                bus.op_a_i   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
                case ($urandom_range(0, 3))
                    0:       bus.op_b_i = 32'd0;
                    1:       bus.op_b_i = 32'($urandom_range(1, 20));
                    default: bus.op_b_i = $urandom;
                endcase
                bus.wr_hi_i = (r == 3) || (r == 5);
                bus.wr_lo_i = (r == 4) || (r == 5) || (r == 8);
                bus.wdata_i = $urandom;
                bus.rd_hi_i = (r == 6) || ((r == 9) && ($urandom_range(0, 1) == 1));
                bus.rd_lo_i = (r == 7);
            end
            bus.flush_i = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            held = bus.stall_o;
            tick();
        end

        rst = 1'b0;
        clear_inputs();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
